cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among NUM_REQ functional units (ALU, mult/div, branch, LSQ) that complete instructions dispatched into the RS/ROB/LSQ/BQ.
- Each requester has a one-deep holding slot. A round-robin arbiter selects one held result per cycle and drives it onto a registered CDB broadcast.
- The broadcast feeds RS wakeup, ROB ready-marking and the physical regfile write.
- A flush input discards all in-flight results on branch mispredict.

Parameters:
- NUM_REQ, 4, number of requesting functional units (any value 2..8, not required to be a power of two).
- ROBSIZE_BITS, 4, ROB index width.
- PR_BITS, 6, physical register index width.
- DATA_W, 32, result data width.
- SRC_BITS (localparam), max(1, $clog2(NUM_REQ)), requester index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  discard all held and outgoing results (mispredict recovery).
- req_valid  in  [NUM_REQ]  requester i presents a result.
- req_ready  out  [NUM_REQ]  slot i can accept this cycle.
- req_rob_id  in  [ROBSIZE_BITS] x NUM_REQ  ROB index of the result.
- req_pd  in  [PR_BITS] x NUM_REQ  physical destination (0 = no regfile write).
- req_rd  in  5 x NUM_REQ  architectural destination.
- req_data  in  [DATA_W] x NUM_REQ  result value.
- cdb_valid  out  1  broadcast valid.
- cdb_rob_id  out  ROBSIZE_BITS  broadcast ROB index.
- cdb_pd  out  PR_BITS  broadcast physical destination.
- cdb_rd  out  5  broadcast architectural destination.
- cdb_data  out  DATA_W  broadcast value.
- cdb_src  out  SRC_BITS  index of the requester that produced the broadcast.

Behaviour:
- State:
  - hold_v[i] plus hold payload per requester.
  - rr_ptr (SRC_BITS), range 0..NUM_REQ-1.
  - Registered cdb_* outputs.
- Reset (rst_n=0 at posedge):
  - hold_v = 0, rr_ptr = 0.
  - cdb_valid = 0; cdb_rob_id, cdb_pd, cdb_rd, cdb_data and cdb_src = 0.
  - req_ready is combinationally forced to 0 while rst_n=0.
- Grant (combinational, one-hot or none):
  - Scan indices rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - The first i with hold_v[i]=1 is granted.
  - Grant depends only on hold_v and rr_ptr, never on req_valid, so there is no combinational loop.
- req_ready[i] = rst_n & ~flush & (~hold_v[i] | grant[i]). A slot being drained this cycle may refill in the same cycle.
- Slot update at posedge:
  - If req_valid[i] & req_ready[i]: hold_v[i] <= 1 and the payload is captured.
  - Else if grant[i]: hold_v[i] <= 0.
- CDB update at posedge:
  - If a grant occurred: cdb_valid <= 1, cdb_* <= hold payload of the granted slot, cdb_src <= granted index, and rr_ptr <= (granted+1) wrapping at NUM_REQ.
  - If no grant: cdb_valid <= 0, the cdb payload holds its previous value, and rr_ptr is unchanged.
- Latency:
  - A request accepted at edge t is visible on the CDB at the earliest after edge t+1.
  - Maximum throughput is 1 broadcast/cycle. Each requester sustains 1 result/cycle when uncontended.
- pd=0 results are broadcast normally; the ROB still needs the completion. Receivers gate the regfile write on pd≠0.
- Fairness: with all slots full, each requester is granted exactly once every NUM_REQ cycles. The bound on starvation is NUM_REQ-1 cycles after the slot fills.
- Flush (sampled at posedge, rst_n=1):
  - hold_v <= 0, cdb_valid <= 0, rr_ptr <= 0.
  - req_ready = 0 during the flush cycle, so there are no captures.
  - A broadcast already registered before the flush edge remains visible for its one cycle. Only the next cycle is suppressed.
- Reset mid-operation behaves identically to power-on reset. Reset dominates flush.
- No back-pressure on the CDB: receivers always accept.

Test Plan:
- Reset, then single request: rst_n=0 for 2 cycles, then req_valid[2]=1 for one cycle with rob_id=5, pd=9, data=0xDEADBEEF.
  - req_ready is 0 during reset.
  - Two cycles after acceptance: cdb_valid=1, cdb_src=2, cdb_rob_id=5, cdb_pd=9, cdb_data=0xDEADBEEF.
  - The following cycle: cdb_valid=0.
- All 4 requesters continuously valid from rr_ptr=0.
  - Broadcasts are ordered src 0,1,2,3,0,1... with one per cycle and no gaps.
  - Each req_ready[i] pulses exactly when grant[i].
- Back-to-back single requester: req_valid[1]=1 for 8 consecutive cycles with rob_id 0..7.
  - req_ready[1] stays 1 throughout.
  - CDB shows rob_id 0..7 on 8 consecutive cycles, in order.
- Contention plus wrap with NUM_REQ=3:
  - Setup: slots 0 and 2 full, rr_ptr=2.
  - Grant order is src 2 then src 0, and rr_ptr wraps 2→0→1.
  - Rerun at NUM_REQ=5 to check non-power-of-two wrap.
- Flush with 3 full slots:
  - Assert flush for 1 cycle; hold_v becomes 0.
  - The cycle after the flush edge shows cdb_valid=0.
  - Requests presented in the flush cycle are dropped (req_ready=0); requests presented afterwards are accepted normally from rr_ptr=0.
- pd=0 request (store/branch result):
  - Broadcast occurs with cdb_pd=0 and the correct cdb_rob_id.
  - A simultaneous pd≠0 request is served on the next cycle per round-robin order.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-deep holding slot per functional unit and a
// round-robin pick of one held result per cycle onto a registered broadcast.
module cdb_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int ROBSIZE_BITS = 4,
  parameter  int PR_BITS      = 6,
  parameter  int DATA_W       = 32,
  localparam int SRC_BITS     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   flush,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ-1:0][ROBSIZE_BITS-1:0]   req_rob_id,
  input  logic [NUM_REQ-1:0][PR_BITS-1:0]        req_pd,
  input  logic [NUM_REQ-1:0][4:0]                req_rd,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]         req_data,
  output logic                                   cdb_valid,
  output logic [ROBSIZE_BITS-1:0]                cdb_rob_id,
  output logic [PR_BITS-1:0]                     cdb_pd,
  output logic [4:0]                             cdb_rd,
  output logic [DATA_W-1:0]                      cdb_data,
  output logic [SRC_BITS-1:0]                    cdb_src
);

  localparam int SW = SRC_BITS + 1;
  localparam logic [SW-1:0]       NUM_REQ_W = SW'(NUM_REQ);
  localparam logic [SRC_BITS-1:0] LAST_IDX  = SRC_BITS'(NUM_REQ - 1);

  logic [NUM_REQ-1:0]      hold_v_r;
  logic [ROBSIZE_BITS-1:0] hold_rob_r  [NUM_REQ];
  logic [PR_BITS-1:0]      hold_pd_r   [NUM_REQ];
  logic [4:0]              hold_rd_r   [NUM_REQ];
  logic [DATA_W-1:0]       hold_data_r [NUM_REQ];
  logic [SRC_BITS-1:0]     rr_ptr_r;

  logic [NUM_REQ-1:0]      grant_s;
  logic [NUM_REQ-1:0]      req_ready_s;
  logic [SRC_BITS-1:0]     grant_idx_s;
  logic [SRC_BITS-1:0]     rr_next_s;
  logic                    grant_any_s;

  // Round-robin scan over held slots starting at rr_ptr; first hit wins.
  always_comb begin
    logic [SW-1:0]       scan_v;
    logic [SRC_BITS-1:0] slot_v;
    logic                hit_v;
    grant_s     = {NUM_REQ{1'b0}};
    grant_idx_s = {SRC_BITS{1'b0}};
    grant_any_s = 1'b0;
    scan_v      = {SW{1'b0}};
    slot_v      = {SRC_BITS{1'b0}};
    hit_v       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_v = {1'b0, rr_ptr_r} + SW'(k);
      scan_v = (scan_v >= NUM_REQ_W) ? (scan_v - NUM_REQ_W) : scan_v;
      slot_v = scan_v[SRC_BITS-1:0];
      hit_v  = hold_v_r[slot_v] & ~grant_any_s;
      grant_s[slot_v] = grant_s[slot_v] | hit_v;
      grant_idx_s     = hit_v ? slot_v : grant_idx_s;
      grant_any_s     = grant_any_s | hit_v;
    end
  end

  // A slot being drained this cycle may refill in the same cycle.
  assign req_ready_s = {NUM_REQ{rst_n & ~flush}} & (~hold_v_r | grant_s);
  assign req_ready   = req_ready_s;
  assign rr_next_s   = (grant_idx_s == LAST_IDX) ? {SRC_BITS{1'b0}}
                                                 : grant_idx_s + SRC_BITS'(1);

  // Payload capture; req_ready already excludes reset and flush cycles.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] & req_ready_s[i]) begin
        hold_rob_r[i]  <= req_rob_id[i];
        hold_pd_r[i]   <= req_pd[i];
        hold_rd_r[i]   <= req_rd[i];
        hold_data_r[i] <= req_data[i];
      end
    end
  end

  // Slot occupancy, round-robin pointer and the registered broadcast.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_v_r   <= {NUM_REQ{1'b0}};
      rr_ptr_r   <= {SRC_BITS{1'b0}};
      cdb_valid  <= 1'b0;
      cdb_rob_id <= {ROBSIZE_BITS{1'b0}};
      cdb_pd     <= {PR_BITS{1'b0}};
      cdb_rd     <= 5'd0;
      cdb_data   <= {DATA_W{1'b0}};
      cdb_src    <= {SRC_BITS{1'b0}};
    end else if (flush) begin
      hold_v_r  <= {NUM_REQ{1'b0}};
      rr_ptr_r  <= {SRC_BITS{1'b0}};
      cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] & req_ready_s[i]) begin
          hold_v_r[i] <= 1'b1;
        end else if (grant_s[i]) begin
          hold_v_r[i] <= 1'b0;
        end
      end
      if (grant_any_s) begin
        cdb_valid  <= 1'b1;
        cdb_rob_id <= hold_rob_r[grant_idx_s];
        cdb_pd     <= hold_pd_r[grant_idx_s];
        cdb_rd     <= hold_rd_r[grant_idx_s];
        cdb_data   <= hold_data_r[grant_idx_s];
        cdb_src    <= grant_idx_s;
        rr_ptr_r   <= rr_next_s;
      end else begin
        cdb_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: per-cycle slot/round-robin model for the 4-requester
// instance plus directed literal checks, including 3- and 5-requester wrap.
module tb_cdb_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  logic [3:0]       valid4;
  logic [3:0][3:0]  rob4;
  logic [3:0][5:0]  pd4;
  logic [3:0][4:0]  rd4;
  logic [3:0][31:0] data4;
  logic [3:0]       ready4;
  logic             cv4;
  logic [3:0]       crob4;
  logic [5:0]       cpd4;
  logic [4:0]       crd4;
  logic [31:0]      cdata4;
  logic [1:0]       csrc4;

  logic [2:0]  valid3, ready3;
  logic        cv3;
  logic [3:0]  crob3;
  logic [5:0]  cpd3;
  logic [4:0]  crd3;
  logic [31:0] cdata3;
  logic [1:0]  csrc3;

  logic [4:0]  valid5, ready5;
  logic        cv5;
  logic [3:0]  crob5;
  logic [5:0]  cpd5;
  logic [4:0]  crd5;
  logic [31:0] cdata5;
  logic [2:0]  csrc5;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(4)) u4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(valid4), .req_ready(ready4), .req_rob_id(rob4), .req_pd(pd4),
    .req_rd(rd4), .req_data(data4), .cdb_valid(cv4), .cdb_rob_id(crob4),
    .cdb_pd(cpd4), .cdb_rd(crd4), .cdb_data(cdata4), .cdb_src(csrc4));

  cdb_arbiter #(.NUM_REQ(3)) u3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(valid3), .req_ready(ready3), .req_rob_id('0), .req_pd('0),
    .req_rd('0), .req_data('0), .cdb_valid(cv3), .cdb_rob_id(crob3),
    .cdb_pd(cpd3), .cdb_rd(crd3), .cdb_data(cdata3), .cdb_src(csrc3));

  cdb_arbiter #(.NUM_REQ(5)) u5 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(valid5), .req_ready(ready5), .req_rob_id('0), .req_pd('0),
    .req_rd('0), .req_data('0), .cdb_valid(cv5), .cdb_rob_id(crob5),
    .cdb_pd(cpd5), .cdb_rd(crd5), .cdb_data(cdata5), .cdb_src(csrc5));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which slots hold a result, their payloads, and the pointer.
  bit          mv [4];
  logic [3:0]  mrob [4];
  logic [5:0]  mpd [4];
  logic [4:0]  mrd [4];
  logic [31:0] mdata [4];
  int          mptr = 0;
  bit          known = 1'b0;
  logic        ev;
  logic [3:0]  erob;
  logic [5:0]  epd;
  logic [4:0]  erd;
  logic [31:0] edata;
  logic [1:0]  esrc;
  int          w;
  logic [3:0]  erdy;

  // Compare at each negedge, then advance the model to the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && mv[(mptr + k) % 4]) w = (mptr + k) % 4;
      for (int i = 0; i < 4; i++)
        erdy[i] = rst_n && !flush && (!mv[i] || w == i);
      if (known || !rst_n) chk("model_ready", 64'(ready4), 64'(erdy));
      if (known) begin
        chk("model_cdb_valid", 64'(cv4), 64'(ev));
        chk("model_cdb_rob", 64'(crob4), 64'(erob));
        chk("model_cdb_pd", 64'(cpd4), 64'(epd));
        chk("model_cdb_rd", 64'(crd4), 64'(erd));
        chk("model_cdb_data", 64'(cdata4), 64'(edata));
        chk("model_cdb_src", 64'(csrc4), 64'(esrc));
      end
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) mv[i] = 1'b0;
        mptr = 0; ev = 1'b0; erob = '0; epd = '0; erd = '0; edata = '0; esrc = '0;
        known = 1'b1;
      end else if (flush) begin
        for (int i = 0; i < 4; i++) mv[i] = 1'b0;
        mptr = 0; ev = 1'b0;
      end else begin
        if (w >= 0) begin
          ev = 1'b1; erob = mrob[w]; epd = mpd[w]; erd = mrd[w]; edata = mdata[w];
          esrc = 2'(w); mptr = (w + 1) % 4;
        end else begin
          ev = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
          if (valid4[i] && erdy[i]) begin
            mv[i] = 1'b1; mrob[i] = rob4[i]; mpd[i] = pd4[i];
            mrd[i] = rd4[i]; mdata[i] = data4[i];
          end else if (i == w) begin
            mv[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    valid4 = '0; rob4 = '0; pd4 = '0; rd4 = '0; data4 = '0;
    valid3 = '0; valid5 = '0;

    // Reset, then a single request on slot 2.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 64'(ready4), 64'(4'b0000));
    chk("reset_cdb_valid", 64'(cv4), 64'(1'b0));
    chk("reset_cdb_data", 64'(cdata4), 64'(32'h0));
    rst_n = 1'b1;
    valid4 = 4'b0100; rob4[2] = 4'd5; pd4[2] = 6'd9; rd4[2] = 5'd7; data4[2] = 32'hDEADBEEF;
    tick();
    valid4 = '0;
    chk("single_not_yet", 64'(cv4), 64'(1'b0));
    tick();
    chk("single_valid", 64'(cv4), 64'(1'b1));
    chk("single_src", 64'(csrc4), 64'(2'd2));
    chk("single_rob", 64'(crob4), 64'(4'd5));
    chk("single_pd", 64'(cpd4), 64'(6'd9));
    chk("single_data", 64'(cdata4), 64'(32'hDEADBEEF));
    tick();
    chk("single_gone", 64'(cv4), 64'(1'b0));

    // All requesters continuously valid from rr_ptr = 0.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    valid4 = 4'hF;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 4; i++) begin
        rob4[i] = 4'(c + i); pd4[i] = 6'(c * 4 + i); rd4[i] = 5'(c + 2 * i);
        data4[i] = $urandom;
      end
      tick();
      if (c >= 1) begin
        chk("rr_valid", 64'(cv4), 64'(1'b1));
        chk("rr_order", 64'(csrc4), 64'((c - 1) % 4));
      end
    end
    valid4 = '0;
    repeat (5) tick();

    // Back-to-back results from requester 1.
    for (int k = 0; k < 8; k++) begin
      valid4 = 4'b0010; rob4[1] = 4'(k); pd4[1] = 6'(k + 1); data4[1] = 32'(k * 3);
      #0;
      chk("b2b_ready", 64'(ready4[1]), 64'(1'b1));
      tick();
      if (k > 0) begin
        chk("b2b_valid", 64'(cv4), 64'(1'b1));
        chk("b2b_rob", 64'(crob4), 64'(k - 1));
      end
    end
    valid4 = '0;
    tick();
    chk("b2b_last", 64'(crob4), 64'(4'd7));
    tick();

    // Flush with three full slots (pointer is 2 here).
    valid4 = 4'hF;
    for (int i = 0; i < 4; i++) rob4[i] = 4'(8 + i);
    tick();
    valid4 = '0;
    tick();
    chk("pre_flush_src", 64'(csrc4), 64'(2'd2));
    flush = 1'b1; valid4 = 4'b0100; rob4[2] = 4'd15;
    #0;
    chk("flush_ready", 64'(ready4), 64'(4'b0000));
    chk("flush_cycle_bcast", 64'(cv4), 64'(1'b1));
    tick();
    chk("post_flush_valid", 64'(cv4), 64'(1'b0));
    flush = 1'b0; valid4 = 4'b0101; rob4[0] = 4'd1; rob4[2] = 4'd2;
    tick();
    valid4 = '0;
    chk("dropped_in_flush", 64'(cv4), 64'(1'b0));
    tick();
    chk("after_flush_src0", 64'(csrc4), 64'(2'd0));
    chk("after_flush_rob0", 64'(crob4), 64'(4'd1));
    tick();
    chk("after_flush_src2", 64'(csrc4), 64'(2'd2));
    chk("after_flush_rob2", 64'(crob4), 64'(4'd2));
    tick();

    // pd = 0 result on slot 3 alongside a pd != 0 result on slot 1 (pointer 3).
    valid4 = 4'b1010;
    rob4[3] = 4'd11; pd4[3] = 6'd0; rob4[1] = 4'd12; pd4[1] = 6'd17;
    tick();
    valid4 = '0;
    tick();
    chk("pd0_src", 64'(csrc4), 64'(2'd3));
    chk("pd0_pd", 64'(cpd4), 64'(6'd0));
    chk("pd0_rob", 64'(crob4), 64'(4'd11));
    tick();
    chk("pdn_src", 64'(csrc4), 64'(2'd1));
    chk("pdn_pd", 64'(cpd4), 64'(6'd17));
    chk("pdn_rob", 64'(crob4), 64'(4'd12));

    // Contention and pointer wrap at NUM_REQ = 3 and 5.
    valid3 = 3'b010; valid5 = 5'b01000;
    tick();
    valid3 = 3'b101; valid5 = 5'b10001;
    tick();
    valid3 = '0; valid5 = '0;
    chk("wrap3_a", 64'(csrc3), 64'(2'd1));
    chk("wrap5_a", 64'(csrc5), 64'(3'd3));
    tick();
    chk("wrap3_b", 64'(csrc3), 64'(2'd2));
    chk("wrap5_b", 64'(csrc5), 64'(3'd4));
    chk("wrap3_bv", 64'(cv3), 64'(1'b1));
    tick();
    chk("wrap3_c", 64'(csrc3), 64'(2'd0));
    chk("wrap5_c", 64'(csrc5), 64'(3'd0));
    chk("wrap5_cv", 64'(cv5), 64'(1'b1));
    valid3 = 3'b011; valid5 = 5'b00011;
    tick();
    valid3 = '0; valid5 = '0;
    chk("wrap3_idle", 64'(cv3), 64'(1'b0));
    chk("wrap5_idle", 64'(cv5), 64'(1'b0));
    tick();
    chk("wrap3_d", 64'(csrc3), 64'(2'd1));
    chk("wrap5_d", 64'(csrc5), 64'(3'd1));
    tick();
    chk("wrap3_e", 64'(csrc3), 64'(2'd0));
    chk("wrap5_e", 64'(csrc5), 64'(3'd0));

    // Mid-operation reset behaves like power-on reset.
    valid4 = 4'hF;
    tick();
    rst_n = 1'b0;
    #0;
    chk("midreset_ready", 64'(ready4), 64'(4'b0000));
    tick();
    chk("midreset_cdb", 64'(cv4), 64'(1'b0));
    chk("midreset_src", 64'(csrc4), 64'(2'd0));
    valid4 = '0;
    rst_n = 1'b1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
